sample_packer: RTL and testbench

- Serial-to-parallel packer that drives the bus-input side of the mean calculator.
- Accepts one DATA_WIDTH sample per cycle over a valid/ready handshake.
- Assembles BUS_WIDTH consecutive samples into an unpacked lane array and presents it as one bus word with o_valid.
- A 2-stage structure (collect register plus output register) lets collection of the next group continue while the current word waits on backpressure.

---
 rtl/sample_packer_if.sv | 27 ++
 rtl/sample_packer.sv | 98 +++++++++
 tb/tb_sample_packer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/sample_packer_if.sv
// Handshake bundle for sample_packer: sample stream in, packed lane word out.
// SAMPLE_PACKER_FLUSH_EN adds i_flush and o_count.
interface sample_packer_if #(
   parameter int BUS_WIDTH  = 4,
   parameter int DATA_WIDTH = 6
);
   logic                  i_valid;
   logic                  i_ready;
   logic [DATA_WIDTH-1:0] i_data;
   logic                  o_valid;
   logic                  o_ready;
   logic [DATA_WIDTH-1:0] o_data [0:BUS_WIDTH-1];
`ifdef SAMPLE_PACKER_FLUSH_EN
   logic                        i_flush;
   logic [$clog2(BUS_WIDTH):0]  o_count;

   modport master (output i_valid, i_data, o_ready, i_flush,
                   input  i_ready, o_valid, o_data, o_count);
   modport slave  (input  i_valid, i_data, o_ready, i_flush,
                   output i_ready, o_valid, o_data, o_count);
`else
   modport master (output i_valid, i_data, o_ready,
                   input  i_ready, o_valid, o_data);
   modport slave  (input  i_valid, i_data, o_ready,
                   output i_ready, o_valid, o_data);
`endif
endinterface

// File: rtl/sample_packer.sv
// Serial-to-parallel packer: BUS_WIDTH samples per word, collect + output register.
// Optional partial-group flush with lane count under SAMPLE_PACKER_FLUSH_EN.
module sample_packer #(
  parameter int BUS_WIDTH  = 4,
  parameter int DATA_WIDTH = 6
) (
  input logic            clk,
  input logic            rst,
  sample_packer_if.slave bus
);
  localparam int IDX_W = $clog2(BUS_WIDTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BUS_WIDTH - 1);

  if (BUS_WIDTH < 2 || (BUS_WIDTH & (BUS_WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "sample_packer: BUS_WIDTH must be a power of 2 and >= 2");
  end

  typedef enum logic {EMPTY, FULL} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] collect_q [BUS_WIDTH];
  logic [DATA_WIDTH-1:0] collect_d [BUS_WIDTH];
  logic [DATA_WIDTH-1:0] out_q [BUS_WIDTH];
  logic [DATA_WIDTH-1:0] out_d [BUS_WIDTH];
  logic                  loadable, in_ready, accept, complete, emit;
`ifdef SAMPLE_PACKER_FLUSH_EN
  logic [CNT_W-1:0]      count_q, count_d, fill;
`endif

  always_comb begin
    loadable  = (state_q == EMPTY) || bus.o_ready;
    in_ready  = !(idx_q == LAST && state_q == FULL && !bus.o_ready);
`ifdef SAMPLE_PACKER_FLUSH_EN
    // A pending flush blocks input until the word can actually be emitted
    in_ready  = in_ready && !(bus.i_flush && !loadable);
`endif
    accept    = bus.i_valid && in_ready;
    complete  = accept && (idx_q == LAST);

    collect_d = collect_q;
    if (accept) collect_d[idx_q] = bus.i_data;
    idx_d     = accept ? idx_q + IDX_W'(1) : idx_q;

    state_d   = state_q;
    out_d     = out_q;
`ifdef SAMPLE_PACKER_FLUSH_EN
    count_d   = count_q;
    fill      = CNT_W'(idx_q) + CNT_W'(accept);
    emit      = complete || (bus.i_flush && loadable && fill != '0);
`else
    emit      = complete;
`endif

    if (emit) begin
      state_d = FULL;
`ifdef SAMPLE_PACKER_FLUSH_EN
      idx_d   = '0;
      count_d = fill;
      // Lanes beyond the fill point may hold stale samples from earlier groups
      for (int unsigned l = 0; l < BUS_WIDTH; l++)
        out_d[l] = (CNT_W'(l) < fill) ? collect_d[l] : '0;
`else
      out_d   = collect_d;
`endif
    end else if (state_q == FULL && bus.o_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      idx_q     <= '0;
      collect_q <= '{default: '0};
      out_q     <= '{default: '0};
`ifdef SAMPLE_PACKER_FLUSH_EN
      count_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      collect_q <= collect_d;
      out_q     <= out_d;
`ifdef SAMPLE_PACKER_FLUSH_EN
      count_q   <= count_d;
`endif
    end
  end

  assign bus.i_ready = in_ready;
  assign bus.o_valid = (state_q == FULL);
  assign bus.o_data  = out_q;
`ifdef SAMPLE_PACKER_FLUSH_EN
  assign bus.o_count = count_q;
`endif
endmodule

// File: tb/tb_sample_packer.sv
// Self-checking bench for sample_packer: directed scenarios plus random traffic
// against a queue-based reference model.
`timescale 1ns/1ps
module tb_sample_packer;
   localparam int BW = 4;
   localparam int DW = 6;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   // Reference model: samples of the group in progress, and the word on the output
   int   grp[$];
   int   held[BW];
   bit   held_v;
   int   held_cnt;

   sample_packer_if #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) bus ();
   sample_packer #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] dut_word();
      logic [63:0] r = '0;
      for (int i = 0; i < BW; i++) r[i*DW +: DW] = bus.o_data[i];
      return r;
   endfunction

   function automatic logic [63:0] model_word();
      logic [63:0] r = '0;
      for (int i = 0; i < BW; i++) r[i*DW +: DW] = DW'(held[i]);
      return r;
   endfunction

   function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
      logic [63:0] r = '0;
      r[0*DW +: DW] = DW'(a);
      r[1*DW +: DW] = DW'(b);
      r[2*DW +: DW] = DW'(c);
      r[3*DW +: DW] = DW'(d);
      return r;
   endfunction

   task automatic model_reset();
      grp.delete();
      for (int i = 0; i < BW; i++) held[i] = 0;
      held_v   = 1'b0;
      held_cnt = 0;
   endtask

   task automatic check_outputs();
      check("o_valid", 64'(bus.o_valid), 64'(held_v));
      check("o_data", dut_word(), model_word());
`ifdef SAMPLE_PACKER_FLUSH_EN
      check("o_count", 64'(bus.o_count), 64'(held_cnt));
`endif
   endtask

   // Called at a falling edge: drive, check i_ready, advance model, wait one cycle, check outputs.
   task automatic cycle(input bit v, input int d, input bit ordy, input bit fl);
      bit exp_rdy, acc, xfer, emit;
      bus.i_valid = v;
      bus.i_data  = DW'(d);
      bus.o_ready = ordy;
`ifdef SAMPLE_PACKER_FLUSH_EN
      bus.i_flush = fl;
`endif
      #1;
      exp_rdy = !(grp.size() == BW - 1 && held_v && !ordy);
`ifdef SAMPLE_PACKER_FLUSH_EN
      exp_rdy = exp_rdy && !(fl && held_v && !ordy);
`endif
      check("i_ready", 64'(bus.i_ready), 64'(exp_rdy));
      acc  = v && exp_rdy;
      xfer = held_v && ordy;
      if (acc) grp.push_back(d & ((1 << DW) - 1));
      emit = (grp.size() == BW);
`ifdef SAMPLE_PACKER_FLUSH_EN
      if (fl && (!held_v || ordy) && grp.size() > 0) emit = 1'b1;
`endif
      if (emit) begin
         for (int i = 0; i < BW; i++) held[i] = (i < grp.size()) ? grp[i] : 0;
         held_cnt = grp.size();
         grp.delete();
         held_v = 1'b1;
      end else if (xfer) begin
         held_v = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check_outputs();
   endtask

   // Reset asserted alongside an offered transfer in both directions; reset must win.
   task automatic do_reset();
      rst = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_data  = DW'(33);
      bus.o_ready = 1'b1;
`ifdef SAMPLE_PACKER_FLUSH_EN
      bus.i_flush = 1'b0;
`endif
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.i_valid = 1'b0;
      model_reset();
      #1;
      check("rst_o_valid", 64'(bus.o_valid), 64'd0);
      check("rst_o_data", dut_word(), 64'd0);
      check("rst_i_ready", 64'(bus.i_ready), 64'd1);
   endtask

   initial begin
      bus.i_valid = 1'b0;
      bus.i_data  = '0;
      bus.o_ready = 1'b0;
`ifdef SAMPLE_PACKER_FLUSH_EN
      bus.i_flush = 1'b0;
`endif
      model_reset();
      @(negedge clk);
      do_reset();

      // Basic packing
      for (int k = 1; k <= 4; k++) cycle(1'b1, k, 1'b1, 1'b0);
      check("basic_valid", 64'(bus.o_valid), 64'd1);
      check("basic_word", dut_word(), pack4(1, 2, 3, 4));
      cycle(1'b0, 0, 1'b1, 1'b0);
      check("basic_drop", 64'(bus.o_valid), 64'd0);

      // Gaps inside a group
      cycle(1'b1, 10, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      cycle(1'b1, 11, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b0);
      cycle(1'b1, 12, 1'b1, 1'b0);
      cycle(1'b1, 13, 1'b1, 1'b0);
      check("gap_word", dut_word(), pack4(10, 11, 12, 13));
      cycle(1'b0, 0, 1'b1, 1'b0);

      // Backpressure: last lane stalls while a word is held
      for (int k = 1; k <= 7; k++) cycle(1'b1, k, 1'b0, 1'b0);
      check("bp_hold", dut_word(), pack4(1, 2, 3, 4));
      cycle(1'b1, 8, 1'b0, 1'b0);
      check("bp_still_hold", dut_word(), pack4(1, 2, 3, 4));
      cycle(1'b1, 8, 1'b1, 1'b0);
      check("bp_reload_valid", 64'(bus.o_valid), 64'd1);
      check("bp_reload", dut_word(), pack4(5, 6, 7, 8));
      cycle(1'b0, 0, 1'b1, 1'b0);

      // Back-to-back stream 0..63
      for (int k = 0; k < 64; k++) begin
         cycle(1'b1, k, 1'b1, 1'b0);
         if (k % 4 == 3) check("b2b_word", dut_word(), pack4(k - 3, k - 2, k - 1, k));
      end
      cycle(1'b0, 0, 1'b1, 1'b0);

      // Reset mid-group discards partial samples
      cycle(1'b1, 5, 1'b1, 1'b0);
      cycle(1'b1, 6, 1'b1, 1'b0);
      do_reset();
      for (int k = 7; k <= 10; k++) cycle(1'b1, k, 1'b1, 1'b0);
      check("rst_mid_word", dut_word(), pack4(7, 8, 9, 10));
      cycle(1'b0, 0, 1'b1, 1'b0);

      // Reset while a word is held under backpressure
      for (int k = 40; k <= 43; k++) cycle(1'b1, k, 1'b0, 1'b0);
      do_reset();

`ifdef SAMPLE_PACKER_FLUSH_EN
      cycle(1'b1, 21, 1'b1, 1'b0);
      cycle(1'b1, 22, 1'b1, 1'b0);
      cycle(1'b0, 0, 1'b1, 1'b1);
      check("flush_word", dut_word(), pack4(21, 22, 0, 0));
      check("flush_count", 64'(bus.o_count), 64'd2);
      for (int k = 30; k <= 33; k++) cycle(1'b1, k, 1'b1, 1'b0);
      check("post_flush_word", dut_word(), pack4(30, 31, 32, 33));
      check("post_flush_count", 64'(bus.o_count), 64'd4);
      cycle(1'b0, 0, 1'b1, 1'b1);
`endif

      // Random traffic against the model
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 249) == 0) begin
            do_reset();
         end else begin
            cycle($urandom_range(0, 9) < 7, int'($urandom_range(0, 63)),
                  $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
